// File: rtl/sram_pkg.sv
// Shared encodings and limits for the asynchronous SRAM controller.
package sram_pkg;
   typedef enum logic [2:0] {IDLE, READ, WRITE, HOLD, TURN} state_e;

   localparam int CTR_W  = 4;
   localparam int WS_MAX = 15;
   localparam int TA_MAX = 3;
endpackage

// File: rtl/sram_wait_ctr.sv
// Loadable down-counter that times the READ/WRITE/TURN phases; holds at zero.
module sram_wait_ctr
   import sram_pkg::*;
(
   input  logic             clock,
   input  logic             reset,
   input  logic             load_i,
   input  logic [CTR_W-1:0] load_val_i,
   input  logic             en_i,
   output logic             zero_o
);
   logic [CTR_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i)
         cnt_d = load_val_i;
      else if (en_i && (cnt_q != '0))
         cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/sram_ctrl.sv
// Single-outstanding host port to asynchronous SRAM pin sequencer with programmable
// wait states, a write hold cycle and a post-read bus turnaround.
module sram_ctrl
   import sram_pkg::*;
#(
   parameter int  ADDR_W      = 18,
   parameter int  DATA_W      = 16,
   parameter int  WAIT_STATES = 1,
   parameter int  TURNAROUND  = 1,
   localparam int NLANE       = DATA_W / 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic [NLANE-1:0]  req_be,
   output logic              req_ready,
   output logic [DATA_W-1:0] rdata,
   output logic              rvalid,
   output logic              wdone,
   output logic [ADDR_W-1:0] sram_addr,
   inout  wire  [DATA_W-1:0] sram_data,
   output logic              sram_we_n,
   output logic              sram_oe_n,
   output logic              sram_ce_n,
   output logic [NLANE-1:0]  sram_be_n
);
   if ((DATA_W % 8) != 0 || DATA_W < 8) begin : g_bad_data_w
      $error("sram_ctrl: DATA_W must be a non-zero multiple of 8");
   end
   if (WAIT_STATES < 0 || WAIT_STATES > WS_MAX) begin : g_bad_ws
      $error("sram_ctrl: WAIT_STATES out of range");
   end
   if (TURNAROUND < 0 || TURNAROUND > TA_MAX) begin : g_bad_ta
      $error("sram_ctrl: TURNAROUND out of range");
   end

   localparam logic [CTR_W-1:0] WS_V = CTR_W'(WAIT_STATES);
   localparam logic [CTR_W-1:0] TA_V = (TURNAROUND > 0) ? CTR_W'(TURNAROUND - 1) : '0;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q, rdata_q;
   logic [NLANE-1:0]    be_q, be_n_q, be_n_d, be_nxt;
   logic                rvalid_q, wdone_q;
   logic                ce_n_q, oe_n_q, we_n_q;
   logic                accept, rd_done, wr_done, active_d;
   logic                ctr_load, ctr_en, ctr_zero;
   logic [CTR_W-1:0]    ctr_val;
   logic                drive;

   sram_wait_ctr u_ctr (
      .clock      (clock),
      .reset      (reset),
      .load_i     (ctr_load),
      .load_val_i (ctr_val),
      .en_i       (ctr_en),
      .zero_o     (ctr_zero)
   );

   always_comb begin
      state_d  = state_q;
      ctr_load = 1'b0;
      ctr_val  = '0;
      ctr_en   = 1'b0;
      accept   = 1'b0;
      rd_done  = 1'b0;
      wr_done  = 1'b0;
      case (state_q)
         IDLE: if (req) begin
            accept   = 1'b1;
            state_d  = req_we ? WRITE : READ;
            ctr_load = 1'b1;
            ctr_val  = WS_V;
         end
         READ: if (ctr_zero) begin
            rd_done = 1'b1;
            if (TURNAROUND > 0) begin
               state_d  = TURN;
               ctr_load = 1'b1;
               ctr_val  = TA_V;
            end else begin
               state_d = IDLE;
            end
         end else begin
            ctr_en = 1'b1;
         end
         WRITE: if (ctr_zero) state_d = HOLD; else ctr_en = 1'b1;
         HOLD: begin
            wr_done = 1'b1;
            state_d = IDLE;
         end
         TURN: if (ctr_zero) state_d = IDLE; else ctr_en = 1'b1;
         default: state_d = IDLE;
      endcase
   end

   // Strobes are registered from the next state so they line up with state_q.
   always_comb begin
      active_d = (state_d == READ) || (state_d == WRITE) || (state_d == HOLD);
      be_nxt   = accept ? req_be : be_q;
      be_n_d   = active_d ? ~be_nxt : '1;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         wdata_q  <= '0;
         be_q     <= '0;
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
         wdone_q  <= 1'b0;
         ce_n_q   <= 1'b1;
         oe_n_q   <= 1'b1;
         we_n_q   <= 1'b1;
         be_n_q   <= '1;
      end else begin
         state_q  <= state_d;
         if (accept) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            be_q    <= req_be;
         end
         if (rd_done) rdata_q <= sram_data;
         rvalid_q <= rd_done;
         wdone_q  <= wr_done;
         ce_n_q   <= ~active_d;
         oe_n_q   <= (state_d != READ);
         we_n_q   <= (state_d != WRITE);
         be_n_q   <= be_n_d;
      end
   end

   assign drive     = (state_q == WRITE) || (state_q == HOLD);
   assign sram_data = drive ? wdata_q : 'z;

   assign req_ready = (state_q == IDLE);
   assign rdata     = rdata_q;
   assign rvalid    = rvalid_q;
   assign wdone     = wdone_q;
   assign sram_addr = addr_q;
   assign sram_ce_n = ce_n_q;
   assign sram_oe_n = oe_n_q;
   assign sram_we_n = we_n_q;
   assign sram_be_n = be_n_q;
endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench: a 16-bit controller (1 wait state, 1 turnaround) and a 32-bit one
// (no wait states, no turnaround), each wired to a small byte-laned SRAM model.
module tb_sram_ctrl;
   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   int n_chk  = 0;
   int n_fail = 0;

   // 16-bit instance
   logic        req_a = 0, we_a = 0;
   logic [17:0] addr_a = '0;
   logic [15:0] wdata_a = '0;
   logic [1:0]  be_a = '0;
   logic        ready_a, rvalid_a, wdone_a, we_n_a, oe_n_a, ce_n_a;
   logic [15:0] rdata_a;
   logic [17:0] saddr_a;
   logic [1:0]  ben_a;
   tri   [15:0] bus_a;

   // 32-bit instance
   logic        req_b = 0, we_b = 0;
   logic [19:0] addr_b = '0;
   logic [31:0] wdata_b = '0;
   logic [3:0]  be_b = '0;
   logic        ready_b, rvalid_b, wdone_b, we_n_b, oe_n_b, ce_n_b;
   logic [31:0] rdata_b;
   logic [19:0] saddr_b;
   logic [3:0]  ben_b;
   tri   [31:0] bus_b;

   sram_ctrl #(.ADDR_W(18), .DATA_W(16), .WAIT_STATES(1), .TURNAROUND(1)) dut_a (
      .clock(clock), .reset(reset), .req(req_a), .req_we(we_a), .req_addr(addr_a),
      .req_wdata(wdata_a), .req_be(be_a), .req_ready(ready_a), .rdata(rdata_a),
      .rvalid(rvalid_a), .wdone(wdone_a), .sram_addr(saddr_a), .sram_data(bus_a),
      .sram_we_n(we_n_a), .sram_oe_n(oe_n_a), .sram_ce_n(ce_n_a), .sram_be_n(ben_a));

   sram_ctrl #(.ADDR_W(20), .DATA_W(32), .WAIT_STATES(0), .TURNAROUND(0)) dut_b (
      .clock(clock), .reset(reset), .req(req_b), .req_we(we_b), .req_addr(addr_b),
      .req_wdata(wdata_b), .req_be(be_b), .req_ready(ready_b), .rdata(rdata_b),
      .rvalid(rvalid_b), .wdone(wdone_b), .sram_addr(saddr_b), .sram_data(bus_b),
      .sram_we_n(we_n_b), .sram_oe_n(oe_n_b), .sram_ce_n(ce_n_b), .sram_be_n(ben_b));

   // SRAM models: byte-laned write on any clock edge with we_n low, async read drive.
   // The probe pulls the bus to zero so a released bus reads back as zero.
   logic [15:0] mem_a [0:255];
   logic [31:0] mem_b [0:255];
   bit probe = 0;

   assign bus_a = (!ce_n_a && !oe_n_a) ? mem_a[saddr_a[7:0]] : 'z;
   assign bus_b = (!ce_n_b && !oe_n_b) ? mem_b[saddr_b[7:0]] : 'z;
   assign bus_a = probe ? 16'h0000 : 'z;
   assign bus_b = probe ? 32'h0 : 'z;

   always @(posedge clock) begin
      for (int l = 0; l < 2; l++)
         if (!ce_n_a && !we_n_a && !ben_a[l]) mem_a[saddr_a[7:0]][8*l +: 8] <= bus_a[8*l +: 8];
      for (int l = 0; l < 4; l++)
         if (!ce_n_b && !we_n_b && !ben_b[l]) mem_b[saddr_b[7:0]][8*l +: 8] <= bus_b[8*l +: 8];
   end

   bit overlap = 0;
   always @(negedge clock)
      if ((!oe_n_a && !we_n_a) || (!oe_n_b && !we_n_b)) overlap <= 1'b1;

   // Observation mux so one access task serves both instances.
   bit sel_b = 0;
   wire        o_ready  = sel_b ? ready_b  : ready_a;
   wire        o_rvalid = sel_b ? rvalid_b : rvalid_a;
   wire        o_wdone  = sel_b ? wdone_b  : wdone_a;
   wire        o_we_n   = sel_b ? we_n_b   : we_n_a;
   wire [31:0] o_rdata  = sel_b ? rdata_b  : {16'h0, rdata_a};
   wire [3:0]  o_ben    = sel_b ? ben_b    : {2'b00, ben_a};
   wire [19:0] o_addr   = sel_b ? saddr_b  : {2'b00, saddr_a};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Issue one access; lat counts clock edges from the accept edge to the done pulse.
   task automatic access(input bit b, input bit we, input logic [19:0] addr,
                         input logic [31:0] wd, input logic [3:0] be,
                         output logic [31:0] rd, output int lat, output int welo,
                         output logic [3:0] ben0, output logic [19:0] addr0,
                         output logic rdy_after);
      int n;
      sel_b = b;
      @(negedge clock);
      if (b) begin
         req_b = 1; we_b = we; addr_b = addr; wdata_b = wd; be_b = be;
      end else begin
         req_a = 1; we_a = we; addr_a = addr[17:0]; wdata_a = wd[15:0]; be_a = be[1:0];
      end
      n = 0;
      while (!o_ready && n < 50) begin @(negedge clock); n++; end
      @(negedge clock);
      req_a = 0; req_b = 0;
      lat = 0; welo = 0; ben0 = o_ben; addr0 = o_addr;
      while (!(o_rvalid || o_wdone) && lat < 50) begin
         if (!o_we_n) welo++;
         @(negedge clock);
         lat++;
      end
      rd = o_rdata;
      rdy_after = o_ready;
   endtask

   typedef struct {
      bit          b;
      bit          we;
      logic [19:0] addr;
      logic [31:0] wd;
      logic [3:0]  be;
      logic [31:0] exp_rd;
      int          exp_lat;
      int          exp_welo;
      logic [3:0]  exp_ben;
      logic        exp_rdy;
   } vec_t;

   localparam int NV = 13;
   vec_t vecs [NV];

   initial begin
      logic [31:0] rd;
      logic [3:0]  ben0;
      logic [19:0] addr0;
      logic        rdy;
      int          lat, welo;
      int          acc, pulses, falls, cyc;
      bit          prev_rdy, prev_ce, bad_start, pulse_seen;

      vecs[0]  = '{0, 1, 20'h00044, 32'h0000BEEF, 4'b0011, 32'h0,        3, 2, 4'b0000, 1'b1};
      vecs[1]  = '{0, 0, 20'h00044, 32'h0,        4'b0011, 32'h0000BEEF, 2, 0, 4'b0000, 1'b0};
      vecs[2]  = '{0, 1, 20'h00010, 32'h00001234, 4'b0011, 32'h0,        3, 2, 4'b0000, 1'b1};
      vecs[3]  = '{0, 1, 20'h00010, 32'h0000AB00, 4'b0010, 32'h0,        3, 2, 4'b0001, 1'b1};
      vecs[4]  = '{0, 0, 20'h00010, 32'h0,        4'b0011, 32'h0000AB34, 2, 0, 4'b0000, 1'b0};
      vecs[5]  = '{0, 1, 20'h00010, 32'h0000FFFF, 4'b0000, 32'h0,        3, 2, 4'b0011, 1'b1};
      vecs[6]  = '{0, 0, 20'h00010, 32'h0,        4'b0011, 32'h0000AB34, 2, 0, 4'b0000, 1'b0};
      vecs[7]  = '{1, 1, 20'h80010, 32'hDEADBEEF, 4'b1111, 32'h0,        2, 1, 4'b0000, 1'b1};
      vecs[8]  = '{1, 1, 20'h80010, 32'h00000011, 4'b0001, 32'h0,        2, 1, 4'b1110, 1'b1};
      vecs[9]  = '{1, 1, 20'h80010, 32'h00002200, 4'b0010, 32'h0,        2, 1, 4'b1101, 1'b1};
      vecs[10] = '{1, 1, 20'h80010, 32'h00330000, 4'b0100, 32'h0,        2, 1, 4'b1011, 1'b1};
      vecs[11] = '{1, 1, 20'h80010, 32'h44000000, 4'b1000, 32'h0,        2, 1, 4'b0111, 1'b1};
      vecs[12] = '{1, 0, 20'h80010, 32'h0,        4'b1111, 32'h44332211, 1, 0, 4'b0000, 1'b1};

      // Reset with garbage on the host side.
      req_a = 1; we_a = 1'($urandom); addr_a = 18'($urandom); wdata_a = 16'($urandom); be_a = 2'($urandom);
      req_b = 1; we_b = 1'($urandom); addr_b = 20'($urandom); wdata_b = $urandom;      be_b = 4'($urandom);
      repeat (2) @(negedge clock);
      probe = 1;
      #1;
      chk("rst_strobes_a", {ce_n_a, oe_n_a, we_n_a, ben_a}, 5'b11111);
      chk("rst_strobes_b", {ce_n_b, oe_n_b, we_n_b, ben_b}, 7'b1111111);
      chk("rst_bus_a", bus_a, 16'h0);
      chk("rst_bus_b", bus_b, 32'h0);
      chk("rst_pulses", {rvalid_a, wdone_a, rvalid_b, wdone_b}, 4'b0000);
      chk("rst_ready", {ready_a, ready_b}, 2'b11);
      chk("rst_rdata_addr", {rdata_a, saddr_a}, 34'h0);
      probe = 0;
      @(negedge clock);
      req_a = 0; req_b = 0; reset = 0;
      repeat (2) @(negedge clock);
      chk("post_rst_idle", {ready_a, ce_n_a, oe_n_a, we_n_a, rvalid_a, wdone_a}, 6'b111100);

      // Table-driven accesses.
      for (int i = 0; i < NV; i++) begin
         access(vecs[i].b, vecs[i].we, vecs[i].addr, vecs[i].wd, vecs[i].be,
                rd, lat, welo, ben0, addr0, rdy);
         chk($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
         chk($sformatf("v%0d_be_n", i), ben0, vecs[i].exp_ben);
         chk($sformatf("v%0d_addr", i), addr0, vecs[i].addr);
         chk($sformatf("v%0d_ready_at_done", i), rdy, vecs[i].exp_rdy);
         if (vecs[i].we) chk($sformatf("v%0d_we_cycles", i), welo, vecs[i].exp_welo);
         else            chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rd);
         @(negedge clock);
         chk($sformatf("v%0d_pulse_one_cycle", i), o_rvalid || o_wdone, 1'b0);
      end

      // Back-to-back: req held, alternating write/read to one address.
      sel_b = 0; acc = 1; pulses = 0; falls = 0; cyc = 0; bad_start = 0;
      @(negedge clock);
      req_a = 1; we_a = 1; addr_a = 18'h20; wdata_a = 16'hC0DE; be_a = 2'b11;
      prev_rdy = ready_a; prev_ce = ce_n_a;
      while (pulses < 4 && cyc < 100) begin
         @(negedge clock);
         cyc++;
         if (rvalid_a || wdone_a) pulses++;
         if (!ce_n_a && prev_ce) begin falls++; if (!prev_rdy) bad_start = 1; end
         prev_rdy = ready_a; prev_ce = ce_n_a;
         if (ready_a && pulses < 4) begin
            if (acc < 4) begin we_a = ~we_a; acc++; end
            else req_a = 0;
         end
      end
      req_a = 0;
      repeat (6) begin
         @(negedge clock);
         if (rvalid_a || wdone_a) pulses++;
         if (!ce_n_a && prev_ce) falls++;
         prev_ce = ce_n_a;
      end
      chk("b2b_pulses", pulses, 4);
      chk("b2b_accesses", falls, 4);
      chk("b2b_start_while_busy", bad_start, 1'b0);
      chk("b2b_rdata", rdata_a, 16'hC0DE);

      // Reset during the first WRITE cycle.
      sel_b = 0;
      @(negedge clock);
      req_a = 1; we_a = 1; addr_a = 18'h44; wdata_a = 16'h5555; be_a = 2'b11;
      @(negedge clock);
      req_a = 0;
      chk("midrst_write_started", we_n_a, 1'b0);
      #1 reset = 1; probe = 1;
      #1;
      chk("midrst_strobes", {ce_n_a, oe_n_a, we_n_a, ben_a}, 5'b11111);
      chk("midrst_bus_released", bus_a, 16'h0);
      probe = 0;
      pulse_seen = 0;
      repeat (3) begin @(negedge clock); if (wdone_a || rvalid_a) pulse_seen = 1; end
      reset = 0;
      repeat (3) begin @(negedge clock); if (wdone_a || rvalid_a) pulse_seen = 1; end
      chk("midrst_no_pulse", pulse_seen, 1'b0);
      access(0, 0, 20'h44, 32'h0, 4'b0011, rd, lat, welo, ben0, addr0, rdy);
      chk("midrst_read_known", $isunknown(rd[15:0]), 1'b0);
      chk("midrst_read_latency", lat, 2);

      chk("oe_we_never_both_low", overlap, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/sram_ctrl.md
Name: sram_ctrl

Overview:
Parametrised external asynchronous-SRAM controller that succeeds the fixed 18-bit-address / 16-bit-data RAM interface driven directly by the MIPS core. Converts a single-outstanding req/ready host request into a timed SRAM pin sequence. Sequence timing: configurable wait states, a write hold cycle, and a read-to-next-access bus turnaround. Supports N byte lanes. Sits between the CPU memory port and the board SRAM pins; the testbench RAM model connects to its sram_* side.

Parameters:
ADDR_W, 18, SRAM word-address width
DATA_W, 16, SRAM data width; must be a multiple of 8
NLANE, DATA_W/8, byte lanes (derived, not overridable)
WAIT_STATES, 1, extra access cycles beyond the minimum of one (0..15)
TURNAROUND, 1, idle cycles after every read before the next access (0..3)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
req  in  1  host request; held until accepted
req_we  in  1  1=write, 0=read
req_addr  in  ADDR_W  word address
req_wdata  in  DATA_W  write data
req_be  in  NLANE  byte enables, active-high, bit i = data[8i+7:8i]
req_ready  out  1  controller idle; req accepted on edge where req&req_ready
rdata  out  DATA_W  read data, valid while rvalid
rvalid  out  1  one-cycle read-complete pulse
wdone  out  1  one-cycle write-complete pulse
sram_addr  out  ADDR_W  SRAM address
sram_data  inout  DATA_W  SRAM data bus; driven only in WRITE/HOLD, else Z
sram_we_n  out  1  write enable, active-low
sram_oe_n  out  1  output enable, active-low
sram_ce_n  out  1  chip enable, active-low
sram_be_n  out  NLANE  byte masks, active-low (lane 1 = hb, lane 0 = lb for DATA_W=16)

Behaviour:
- Reset (async, immediate): state IDLE, counter 0, sram_addr 0, rdata 0, rvalid 0, wdone 0, all sram_*_n = 1, sram_data Z. req_ready = 1 (decoded from IDLE).
- States: IDLE, READ, WRITE, HOLD, TURN.
- Address, data, write flag and be are registered at the accept edge and held until return to IDLE/TURN.
- IDLE: req_ready=1. On req&req_ready: enter READ or WRITE; counter loads WAIT_STATES.
- READ, WAIT_STATES+1 cycles:
  - ce_n=0, oe_n=0, we_n=1, be_n=~be.
  - At the final edge (counter==0): rdata<=sram_data, rvalid=1 for the next cycle.
  - Go to TURN if TURNAROUND>0, else IDLE.
  - rvalid is asserted at accept edge + WAIT_STATES+1.
- TURN, TURNAROUND cycles: all strobes high, bus Z, req_ready=0.
- WRITE, WAIT_STATES+1 cycles: ce_n=0, we_n=0, oe_n=1, be_n=~be, bus driven with wdata. Then go to HOLD.
- HOLD, 1 cycle: we_n=1, ce_n=0, addr and data still driven. On exit: wdone=1 for one cycle, go to IDLE. wdone is asserted at accept edge + WAIT_STATES+2.
- sram_oe_n and sram_we_n are never both 0 in any cycle.
- be==0: the access still runs with full timing, with all be_n=1; the memory is unchanged. For a read, rdata captures whatever is on the bus.
- req while busy: ignored, with no queuing. The host holds req, and req_ready rises in the cycle the state returns to IDLE.
- req deasserted in IDLE: no activity, outputs static.
- Reset asserted mid-access: all strobes go high and the bus releases asynchronously; no rvalid/wdone pulse; the in-flight request is lost.
- Counter width is 4 bits; it saturates at 0 and does not wrap.
- All outputs are registered except req_ready and the sram_data tristate enable, which are state decodes.

Decomposition:
- Package sram_pkg: state encoding enum (IDLE, READ, WRITE, HOLD, TURN), counter width constant, parameter range-check constants.
- One sub-module, sram_wait_ctr: loadable 4-bit down-counter with load, enable and zero flag. It is shared by the READ/WRITE/TURN phases.
- Tristate data pad logic stays in the top module.

Test Plan:
- Reset check: reset=1 with random host inputs -> all sram_*_n=1, sram_data=Z, rvalid=wdone=0, req_ready=1. Drop reset -> state unchanged.
- Write then read (WAIT_STATES=1, TURNAROUND=1):
  - Write addr 0x00044, data 0xBEEF, be=2'b11 -> we_n low exactly 2 cycles, wdone pulse 3 cycles after accept.
  - Read addr 0x00044 -> rvalid 2 cycles after accept, rdata=0xBEEF, req_ready low 1 extra cycle (TURN).
- Byte lanes:
  - Preload 0x1234; write 0xAB00 with be=2'b10 -> hb_n=0, lb_n=1; read back 0xAB34.
  - Write with be=2'b00 -> memory stays 0xAB34, wdone still pulses.
- Back-to-back / busy: req held continuously for 4 alternating reads/writes -> exactly 4 pulses. No access starts while req_ready=0. oe_n&we_n are never both low (assertion).
- Reset mid-write: assert reset during the 1st WRITE cycle -> we_n/ce_n high and bus Z in the same timestep, no wdone. After release, a read of that address returns the old value or the new value, and the bench flags only X.
- Parameter sweep: DATA_W=32, ADDR_W=20, WAIT_STATES=0, TURNAROUND=0 -> rvalid at accept+1, wdone at accept+2, 4 independent be_n lanes verified with per-lane writes 0x11/0x22/0x33/0x44 -> read 0x44332211.
